// File: rtl/change_dispenser.sv
// change_dispenser
// ----------------
// Pays out change and refunds through the coin-return hopper. A requested
// amount (in 0.5-yuan units) is broken down greedily into 10, 5, 1 and
// 0.5 yuan coins. One coin is requested at a time:
//   - each request is held until hop_ack arrives or the ack timeout expires;
//   - consecutive coins are separated by a settle gap.
//
// Ports
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-low reset
//   start    : one-cycle payout request, honoured only while idle
//   amount   : amount to pay, 0.5-yuan units, sampled with start
//   clear    : leaves the FAULT state
//   refill   : reloads every stock counter (stock tracking builds only)
//   hop_ack  : hopper confirms one coin ejected (level, synchronous)
//   hop_req  : one-hot eject request, [3]=10y [2]=5y [1]=1y [0]=0.5y
//   busy     : high in every state except IDLE
//   done     : one-cycle pulse when the payout has completed
//   fault    : high while in FAULT
//   remain   : amount not yet dispensed, 0.5-yuan units
//
// Build option
//   STOCK_TRACK_EN : when defined, keeps an 8-bit stock counter per
//                    denomination. Empty denominations are skipped, and
//                    refill reloads the counters. When undefined, stock
//                    is infinite and refill is ignored.

module change_dispenser #(
    parameter int ACK_TIMEOUT = 1000,
    parameter int GAP_CYCLES  = 16,
    parameter int STOCK_INIT  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] amount,
    input  logic       clear,
    input  logic       refill,
    input  logic       hop_ack,
    output logic [3:0] hop_req,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [7:0] remain
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_REQ    = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_FAULT  = 3'd5;

    // One timer serves both the ack timeout and the settle gap.
    localparam int TMAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_CYCLES - 1);

    logic [2:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_hop_req;
    logic [7:0]    r_remain;
    logic          r_busy;
    logic          r_done;
    logic          r_fault;

    logic [2:0]    w_state_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic [3:0]    w_hop_nxt;
    logic [7:0]    w_remain_nxt;
    logic [3:0]    w_avail;
    logic [3:0]    w_pick;
    logic [7:0]    w_coin_val;
    logic          w_take;

    // Value in 0.5-yuan units of the coin selected by a one-hot request.
    function automatic logic [7:0] coin_value(input logic [3:0] oh);
        case (oh)
            4'b1000: coin_value = 8'd20;
            4'b0100: coin_value = 8'd10;
            4'b0010: coin_value = 8'd2;
            4'b0001: coin_value = 8'd1;
            default: coin_value = 8'd0;
        endcase
    endfunction

    assign w_coin_val = coin_value(r_hop_req);
    assign w_take     = (r_state == ST_REQ) && hop_ack;

`ifdef STOCK_TRACK_EN
    logic [3:0][7:0] r_stock;

    // Per-denomination stock; a refill wins over a coincident decrement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) r_stock[i] <= 8'(STOCK_INIT);
        end else if (refill) begin
            for (int i = 0; i < 4; i++) r_stock[i] <= 8'(STOCK_INIT);
        end else if (w_take) begin
            for (int i = 0; i < 4; i++) begin
                if (r_hop_req[i]) r_stock[i] <= r_stock[i] - 8'd1;
            end
        end
    end

    // A denomination may be chosen only while it still has coins.
    always_comb begin
        for (int i = 0; i < 4; i++) w_avail[i] = (r_stock[i] != 8'd0);
    end
`else
    logic w_unused_stock;
    assign w_unused_stock = refill | w_take;
    assign w_avail        = 4'b1111;
`endif

    // Greedy choice: the largest available coin that does not exceed remain.
    always_comb begin
        if (r_remain >= 8'd20 && w_avail[3]) begin
            w_pick = 4'b1000;
        end else if (r_remain >= 8'd10 && w_avail[2]) begin
            w_pick = 4'b0100;
        end else if (r_remain >= 8'd2 && w_avail[1]) begin
            w_pick = 4'b0010;
        end else if (r_remain >= 8'd1 && w_avail[0]) begin
            w_pick = 4'b0001;
        end else begin
            w_pick = 4'b0000;
        end
    end

    // Next-state and next-output computation for the payout sequencer.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_hop_nxt    = r_hop_req;
        w_remain_nxt = r_remain;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_remain_nxt = amount;
                    w_state_nxt  = ST_SELECT;
                end else begin
                    w_hop_nxt = 4'b0000;
                end
            end
            ST_SELECT: begin
                if (r_remain == 8'd0) begin
                    w_state_nxt = ST_DONE;
                end else if (w_pick != 4'b0000) begin
                    w_hop_nxt   = w_pick;
                    w_timer_nxt = '0;
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_FAULT;
                end
            end
            ST_REQ: begin
                // An ack in the timeout cycle still counts as a coin paid.
                if (hop_ack) begin
                    w_remain_nxt = r_remain - w_coin_val;
                    w_hop_nxt    = 4'b0000;
                    w_timer_nxt  = '0;
                    w_state_nxt  = ST_GAP;
                end else if (r_timer == TIMEOUT_LAST) begin
                    w_hop_nxt   = 4'b0000;
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            ST_GAP: begin
                if (r_timer == GAP_LAST) begin
                    w_timer_nxt = '0;
                    w_state_nxt = ST_SELECT;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
                w_hop_nxt = 4'b0000;
                if (clear) begin
                    w_remain_nxt = 8'd0;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_state_nxt = ST_FAULT;
                end
            end
            default: begin
                w_hop_nxt    = 4'b0000;
                w_remain_nxt = 8'd0;
                w_timer_nxt  = '0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; flags are decoded from the next state
    // so that they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_hop_req <= 4'b0000;
            r_remain  <= 8'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_hop_req <= w_hop_nxt;
            r_remain  <= w_remain_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= (w_state_nxt == ST_DONE);
            r_fault   <= (w_state_nxt == ST_FAULT);
        end
    end

    assign hop_req = r_hop_req;
    assign busy    = r_busy;
    assign done    = r_done;
    assign fault   = r_fault;
    assign remain  = r_remain;

endmodule
